// File: rtl/data_memory_ctrl.sv
// Parametrised data memory with valid/ready requests, configurable wait states and a post-reset pattern loader.
// Optional macro DMEM_PARITY_EN adds a per-word even-parity bit and the par_inject input.
module data_memory_ctrl #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DEPTH       = 32,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
`ifdef DMEM_PARITY_EN
  input  logic              par_inject,
`endif
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              init_busy,
  output logic [1:0]        dbg_state
);

  // Handshake: a request is taken on a rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE, and rsp_valid is a one-cycle completion pulse.

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CMP_W = ((ADDR_W > 32) ? ADDR_W : 32) + 1;
`ifdef DMEM_PARITY_EN
  localparam int unsigned MEM_W = DATA_W + 1;
`else
  localparam int unsigned MEM_W = DATA_W;
`endif
  localparam logic [IDX_W-1:0] HALF    = IDX_W'(DEPTH / 2);
  localparam logic [IDX_W-1:0] LAST    = IDX_W'(DEPTH - 1);
  localparam logic [2:0]       WS_LOAD = 3'(WAIT_STATES);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    init_cnt_q, init_cnt_d;
  logic [2:0]          wait_cnt_q, wait_cnt_d;
  logic                write_q, write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                inj_q, inj_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;

  logic [MEM_W-1:0]    mem [DEPTH];
  logic                mem_we;
  logic [IDX_W-1:0]    mem_idx;
  logic [MEM_W-1:0]    mem_wword;
  logic [MEM_W-1:0]    mem_rword;
  logic [DATA_W-1:0]   init_val;
  logic                addr_ok;
  logic                par_bad;
  logic                inj_in;

`ifdef DMEM_PARITY_EN
  assign inj_in  = par_inject;
  assign par_bad = ^mem_rword;
`else
  assign inj_in  = 1'b0;
  assign par_bad = 1'b0;
`endif

  // Range check in a width wide enough that no address bit is dropped.
  assign addr_ok   = (CMP_W'(addr_q) < CMP_W'(DEPTH));
  assign mem_rword = mem[addr_q[IDX_W-1:0]];

  always_comb begin
    if (init_cnt_q < HALF) init_val = DATA_W'(init_cnt_q);
    else                   init_val = DATA_W'(0) - DATA_W'(init_cnt_q - HALF);
  end

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    inj_d       = inj_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = 1'b0;
    mem_we      = 1'b0;
    mem_idx     = addr_q[IDX_W-1:0];
`ifdef DMEM_PARITY_EN
    mem_wword   = {(^wdata_q) ^ inj_q, wdata_q};
`else
    mem_wword   = wdata_q;
`endif
    case (state_q)
      ST_INIT: begin
        mem_we     = 1'b1;
        mem_idx    = init_cnt_q;
`ifdef DMEM_PARITY_EN
        mem_wword  = {^init_val, init_val};
`else
        mem_wword  = init_val;
`endif
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == LAST) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (req_valid) begin
          write_d    = req_write;
          addr_d     = req_addr;
          wdata_d    = req_wdata;
          inj_d      = inj_in;
          wait_cnt_d = WS_LOAD;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q != 3'd0) begin
          wait_cnt_d = wait_cnt_q - 3'd1;
        end else begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b1;
          if (!addr_ok) begin
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b1;
          end else if (write_q) begin
            mem_we = 1'b1;
          end else begin
            rsp_rdata_d = mem_rword[DATA_W-1:0];
            rsp_err_d   = par_bad;
          end
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      wait_cnt_q  <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      inj_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      inj_q       <= inj_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Array has no reset: the INIT walk rewrites every entry after each reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_idx] <= mem_wword;
  end

  assign req_ready = (state_q == ST_IDLE);
  assign init_busy = (state_q == ST_INIT);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Self-checking bench for data_memory_ctrl: vector table, scoreboard queue, reset/throughput sequences.
// Parity sequence is compiled in when DMEM_PARITY_EN is defined.
module tb_data_memory_ctrl;

  localparam int WS = 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0, req_write = 1'b0, par_inject = 1'b0;
  logic [7:0] req_addr = '0, req_wdata = '0;
  logic       req_ready, rsp_valid, rsp_err, init_busy;
  logic [7:0] rsp_rdata;
  logic [1:0] dbg_state;

  logic       b_valid = 1'b0;
  logic [7:0] b_addr = '0;
  logic       b_ready, b_rsp_valid, b_rsp_err, b_init_busy;
  logic [7:0] b_rsp_rdata;
  logic [1:0] b_dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc = 0;

  logic [8:0] exp_q[$];
  int         acc_q[$];

  typedef struct {
    logic       w;
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] rd;
    logic       err;
  } vec_t;
  vec_t tbl[14];

  data_memory_ctrl #(.DATA_W(8), .ADDR_W(8), .DEPTH(32), .WAIT_STATES(WS)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef DMEM_PARITY_EN
    .par_inject(par_inject),
`endif
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .init_busy(init_busy), .dbg_state(dbg_state)
  );

  data_memory_ctrl #(.DATA_W(8), .ADDR_W(8), .DEPTH(32), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .req_valid(b_valid), .req_ready(b_ready),
    .req_write(1'b0), .req_addr(b_addr), .req_wdata(8'h00),
`ifdef DMEM_PARITY_EN
    .par_inject(1'b0),
`endif
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
    .init_busy(b_init_busy), .dbg_state(b_dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] pat(input int a);
    int v;
    v = (a < 16) ? a : -(a - 16);
    return v[7:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // scoreboard: compare data/error and response latency
  logic [8:0] mon_e;
  int         mon_a;
  always @(negedge clk) begin
    if (!reset) begin
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rsp: rsp_valid=1 with nothing outstanding at cycle %0d", cyc);
        end else begin
          mon_e = exp_q.pop_front();
          mon_a = acc_q.pop_front();
          checks++;
          if ({rsp_err, rsp_rdata} !== mon_e) begin
            errors++;
            $display("FAIL rsp_data: got err=%0b rdata=0x%0h expected err=%0b rdata=0x%0h",
                     rsp_err, rsp_rdata, mon_e[8], mon_e[7:0]);
          end
          checks++;
          if (cyc != mon_a + WS + 1) begin
            errors++;
            $display("FAIL rsp_latency: response at edge %0d expected edge %0d", cyc, mon_a + WS + 1);
          end
        end
      end else if (rsp_err) begin
        errors++;
        $display("FAIL err_idle: rsp_err=1 without rsp_valid at cycle %0d", cyc);
      end
    end
  end

  // drive one request; caller is between edges
  task automatic do_req(input logic w, input logic [7:0] a, input logic [7:0] d,
                        input logic inj, input logic [8:0] exp, input bit hold);
    int n;
    n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; par_inject = inj;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      errors++;
      $display("FAIL accept_timeout: req_ready stayed 0 for addr 0x%0h", a);
      req_valid = 1'b0;
      return;
    end
    exp_q.push_back(exp);
    acc_q.push_back(cyc + 1);
    last_acc = cyc + 1;
    @(posedge clk);
    #1;
    if (!hold) begin
      req_valid = 1'b0;
      // inputs change after accept; the in-flight access must not see this
      req_write = 1'($urandom_range(0, 1));
      req_addr = 8'($urandom_range(0, 255));
      req_wdata = 8'($urandom_range(0, 255));
      par_inject = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d responses missing", exp_q.size());
      exp_q.delete();
      acc_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // starts right after reset deassertion, on a negedge
  task automatic check_init();
    int n;
    n = 0;
    while (init_busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("init_busy_cycles", 32'(n), 32'd32);
    check("idle_state", 32'(dbg_state), 32'd1);
    check("ready_after_init", 32'(req_ready), 32'd1);
  endtask

  initial begin
    int a;
    int n;
    int prev;
    tbl[0]  = '{1'b0, 8'd5,   8'h00, 8'h05, 1'b0};
    tbl[1]  = '{1'b0, 8'd20,  8'h00, 8'hFC, 1'b0};
    tbl[2]  = '{1'b0, 8'd31,  8'h00, 8'hF1, 1'b0};
    tbl[3]  = '{1'b1, 8'd3,   8'hA5, 8'hF1, 1'b0};
    tbl[4]  = '{1'b0, 8'd3,   8'h00, 8'hA5, 1'b0};
    tbl[5]  = '{1'b0, 8'd40,  8'h00, 8'h00, 1'b1};
    tbl[6]  = '{1'b1, 8'd40,  8'h77, 8'h00, 1'b1};
    tbl[7]  = '{1'b0, 8'd8,   8'h00, 8'h08, 1'b0};
    tbl[8]  = '{1'b0, 8'd16,  8'h00, 8'h00, 1'b0};
    tbl[9]  = '{1'b0, 8'd17,  8'h00, 8'hFF, 1'b0};
    tbl[10] = '{1'b1, 8'd0,   8'h3C, 8'hFF, 1'b0};
    tbl[11] = '{1'b0, 8'd0,   8'h00, 8'h3C, 1'b0};
    tbl[12] = '{1'b0, 8'd255, 8'h00, 8'h00, 1'b1};
    tbl[13] = '{1'b0, 8'd15,  8'h00, 8'h0F, 1'b0};

    // reset values
    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check("rst_rsp_err",   32'(rsp_err),   32'd0);
    check("rst_init_busy", 32'(init_busy), 32'd1);
    reset = 1'b0;
    check_init();

    // table-driven vectors
    for (int i = 0; i < 14; i++)
      do_req(tbl[i].w, tbl[i].a, tbl[i].d, 1'b0, {tbl[i].err, tbl[i].rd}, 1'b0);
    drain();

    // random reads of untouched entries and out-of-range addresses
    for (int i = 0; i < 12; i++) begin
      a = $urandom_range(8, 31);
      do_req(1'b0, 8'(a), 8'h00, 1'b0, {1'b0, pat(a)}, 1'b0);
      a = $urandom_range(32, 255);
      do_req(1'b0, 8'(a), 8'h00, 1'b0, {1'b1, 8'h00}, 1'b0);
    end
    drain();

    // reset while a write sits in WAIT
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'd3; req_wdata = 8'h99;
    check("pre_abort_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("abort_in_wait", 32'(dbg_state), 32'd2);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    reset = 1'b0;
    check_init();
    do_req(1'b0, 8'd3, 8'h00, 1'b0, {1'b0, 8'h03}, 1'b0);
    drain();

    // back-to-back reads, req_valid held high
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      do_req(1'b0, 8'(k), 8'h00, 1'b0, {1'b0, 8'(k)}, 1'b1);
      if (k > 0) check("b2b_spacing", 32'(last_acc - prev), 32'(WS + 2));
      prev = last_acc;
    end
    #1 req_valid = 1'b0;
    drain();

    // zero-wait-state instance: one response every 2 cycles
    @(negedge clk);
    b_valid = 1'b1;
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      b_addr = 8'(k);
      n = 0;
      while (!b_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("ws0_ready", 32'(b_ready), 32'd1);
      if (k > 0) check("ws0_spacing", 32'(cyc + 1 - prev), 32'd2);
      prev = cyc + 1;
      @(negedge clk);
      @(negedge clk);
      check("ws0_rsp_valid", 32'(b_rsp_valid), 32'd1);
      check("ws0_rsp", {23'd0, b_rsp_err, b_rsp_rdata}, {23'd0, 1'b0, 8'(k)});
    end
    b_valid = 1'b0;
    @(negedge clk);

`ifdef DMEM_PARITY_EN
    do_req(1'b1, 8'd7, 8'h5A, 1'b1, {1'b0, 8'h03}, 1'b0);
    do_req(1'b0, 8'd7, 8'h00, 1'b0, {1'b1, 8'h5A}, 1'b0);
    do_req(1'b1, 8'd7, 8'h5A, 1'b0, {1'b0, 8'h5A}, 1'b0);
    do_req(1'b0, 8'd7, 8'h00, 1'b0, {1'b0, 8'h5A}, 1'b0);
    drain();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_memory_ctrl.md
Name:
data_memory_ctrl

Overview:
Parametrised successor of the 8-bit/32-entry data memory used by the datapath load/store stage. It is generalised in data width, depth and access latency. Requests use a valid/ready handshake, and each access completes after a configurable number of wait states. After every reset, a sequencer walks the whole array and loads the standard test pattern one word per cycle; no reset-time bulk clear is used. Out-of-range addresses are flagged instead of aliased.

Parameters:
DATA_W, 8, word width in bits.
ADDR_W, 8, request address width.
DEPTH, 32, number of words; power of 2, at least 2, at most 2**ADDR_W.
WAIT_STATES, 1, extra cycles inserted before each access; legal range 0..7.

Ports:
clk  in  1  clock, all state on rising edge.
reset  in  1  asynchronous, active-high reset.
req_valid  in  1  request present.
req_ready  out  1  controller can accept a request.
req_write  in  1  1 = write, 0 = read.
req_addr  in  ADDR_W  word address.
req_wdata  in  DATA_W  write data.
rsp_valid  out  1  one-cycle pulse: access completed.
rsp_rdata  out  DATA_W  read data, valid when rsp_valid is high.
rsp_err  out  1  error for this response, valid with rsp_valid.
init_busy  out  1  pattern initialisation in progress.

Behaviour:
- Reset is asynchronous and active-high; clock is clk.
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_busy=1, init counter=0, state=INIT.
- State machine states: INIT, IDLE, WAIT.
- INIT:
  - Each cycle, write entry i=counter, then increment the counter.
  - Entries i < DEPTH/2 get i, truncated to DATA_W.
  - Entries i >= DEPTH/2 get -(i-DEPTH/2), two's complement truncated to DATA_W. Example for DATA_W=8: entry 16 gets 0x00, entry 17 gets 0xFF.
  - After the write of entry DEPTH-1, go to IDLE. init_busy drops after exactly DEPTH cycles.
- Requests are ignored in INIT: req_ready=0.
- IDLE:
  - req_ready=1.
  - A request is accepted on a rising edge where req_valid&req_ready.
  - On acceptance, capture write/addr/wdata into holding registers and load the wait counter with WAIT_STATES.
  - Go to WAIT, where req_ready=0.
- WAIT:
  - On each edge, if the counter is nonzero, decrement it.
  - If the counter is 0, perform the access, go to IDLE, and set rsp_valid=1 for exactly one cycle.
- Latency and throughput:
  - rsp_valid is high during the cycle starting WAIT_STATES+1 edges after the accept edge.
  - req_ready is high in the rsp_valid cycle, so the next request can be accepted at the edge ending that cycle.
  - Peak throughput is one request per WAIT_STATES+2 cycles.
- Read: rsp_rdata=mem[addr], rsp_err=0.
- Write: mem[addr]<=wdata at the access edge. rsp_rdata keeps its previous value, rsp_err=0.
- Out-of-range address (req_addr >= DEPTH):
  - No array write.
  - rsp_rdata=0 and rsp_err=1.
  - The address is never truncated or aliased.
- Between responses, rsp_rdata holds its last value and rsp_err is held low.
- Request inputs are sampled only at the accept edge. Later changes to them have no effect on an in-flight access.
- Reset mid-operation (any state):
  - Abort immediately; no rsp_valid for the aborted access.
  - A pending write is dropped.
  - The array is fully re-initialised to the pattern.
- Array is inferred, single port; there is no byte enable.

Optional Feature:
Macro: DMEM_PARITY_EN.
- With the macro defined:
  - Each word stores an extra even-parity bit, written during INIT and on every write.
  - An extra input port par_inject (1 bit) exists. When it is high on an accepted write, the stored parity bit is inverted.
  - A read whose data/parity check fails returns the stored data with rsp_err=1.
  - Out-of-range behaviour is unchanged.
- Without the macro: no parity storage, no par_inject port, and rsp_err flags out-of-range addresses only.

Test Plan:
(DATA_W=8, DEPTH=32, WAIT_STATES=1 unless stated)
1. Release reset -> init_busy high for exactly 32 cycles. Then read addr 5 -> 0x05, addr 20 -> 0xFC, addr 31 -> 0xF1. rsp_valid is high 2 edges after each accept.
2. Write 0xA5 to addr 3, then read addr 3 -> 0xA5, rsp_err=0. Write response leaves rsp_rdata at its prior value.
3. Read addr 40 -> rsp_valid with rsp_err=1, rdata 0x00. Write 0x77 to addr 40, then read addr 8 -> 0x08 (no aliasing).
4. Hold req_valid high for 4 reads (addr 0..3) -> responses 0x00..0x03, one every 3 cycles. With WAIT_STATES=0 -> one every 2 cycles.
5. Assert reset while a write of 0x99 to addr 3 is in WAIT -> no rsp_valid, init_busy=1 for 32 cycles, then read addr 3 -> 0x03.
6. DMEM_PARITY_EN defined: write 0x5A to addr 7 with par_inject=1, then read addr 7 -> rdata 0x5A, rsp_err=1. Rewrite with par_inject=0, then read -> rsp_err=0.
